// File: rtl/aesl_deadlock_pkg.sv
// Shared definitions for the AESL deadlock watchdog.
// Holds the default values of the parameters, the FSM state encoding and
// a small helper that decodes which states count as "deadlocked".
package aesl_deadlock_pkg;

  localparam int DEF_NUM_AXIS = 8;
  localparam int DEF_NUM_INST = 5;
  localparam int DEF_THRESH   = 1024;
  localparam int DEF_CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_REPORT = 2'd2,
    ST_HALT   = 2'd3
  } wd_state_t;

  function automatic logic is_deadlocked(input wd_state_t s);
    return (s == ST_REPORT) || (s == ST_HALT);
  endfunction

endpackage

// File: rtl/aesl_stall_counter.sv
// Episode counter with a max-length tracker for the deadlock watchdog.
// Counts consecutive blocked cycles of the current episode, and on the
// edge where an episode ends folds its length into max_stall. Both values
// saturate at all-ones.
// Ports:
//   clock, reset     : clock, synchronous active-high reset
//   clear            : synchronous clear of cnt and max_stall
//   start            : begin a new episode (cnt <= 1)
//   incr             : extend the running episode by one cycle
//   end_short        : episode ends; its length is the current cnt
//   end_long         : episode ends including this cycle (length cnt+1)
//   cnt              : running episode length
//   max_stall        : longest episode seen since reset/clear
import aesl_deadlock_pkg::*;

module aesl_stall_counter #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic             incr,
  input  logic             end_short,
  input  logic             end_long,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] max_stall
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] episode_len;
  logic             episode_end;

  always_comb begin
    cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    // The REPORT transition happens on a blocked cycle, so that cycle is
    // part of the episode even though cnt has not counted it yet.
    episode_len = end_long ? cnt_inc : cnt;
    episode_end = end_short | end_long;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt       <= '0;
      max_stall <= '0;
    end else begin
      if (start) begin
        cnt <= CNT_ONE;
      end else if (incr) begin
        cnt <= cnt_inc;
      end else if (episode_end) begin
        cnt <= '0;
      end
      if (episode_end && (episode_len > max_stall)) begin
        max_stall <= episode_len;
      end
    end
  end

endmodule

// File: rtl/aesl_deadlock_watchdog.sv
// Deadlock watchdog: declares deadlock once the monitor's block indication
// has been asserted (with not every instance idle) for THRESH consecutive
// enabled cycles, captures the per-channel block flags at that moment and
// offers them as a valid/ready report, then halts until clear or reset.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | armed or disabled, no blocked episode in progress
//   ST_COUNT  | counting consecutive blocked cycles
//   ST_REPORT | deadlock declared, report_valid held until accepted
//   ST_HALT   | report consumed, deadlock sticky until clear/reset
//
// Ports:
//   clock, reset       : clock, synchronous active-high reset
//   enable             : arms detection (ignored in REPORT/HALT)
//   clear              : one-cycle pulse back to idle, clears results
//   block_in           : registered block indication from the monitor
//   axis_block_sigs    : per-channel block flags
//   inst_idle_sigs     : per-instance idle flags
//   deadlock           : sticky deadlock flag
//   snapshot_axis      : axis_block_sigs captured at detection
//   max_stall          : longest blocked episode, saturating
//   report_valid       : report available
//   report_ready       : report consumer accepts
import aesl_deadlock_pkg::*;

module aesl_deadlock_watchdog #(
  parameter int NUM_AXIS = DEF_NUM_AXIS,
  parameter int NUM_INST = DEF_NUM_INST,
  parameter int THRESH   = DEF_THRESH,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic                block_in,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  output logic                deadlock,
  output logic [NUM_AXIS-1:0] snapshot_axis,
  output logic [CNT_W-1:0]    max_stall,
  output logic                report_valid,
  input  logic                report_ready
);

  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);

  wd_state_t        state;
  wd_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic             blocked;
  logic             cnt_start;
  logic             cnt_incr;
  logic             end_short;
  logic             end_long;
  logic             snap_load;

  assign blocked = block_in & ~(&inst_idle_sigs);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_start  = 1'b0;
    cnt_incr   = 1'b0;
    end_short  = 1'b0;
    end_long   = 1'b0;
    snap_load  = 1'b0;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && blocked) begin
            state_next = ST_COUNT;
            cnt_start  = 1'b1;
          end
        end
        ST_COUNT: begin
          if (enable && blocked) begin
            if (cnt == THRESH_M1) begin
              state_next = ST_REPORT;
              end_long   = 1'b1;
              snap_load  = 1'b1;
            end else begin
              cnt_incr = 1'b1;
            end
          end else begin
            state_next = ST_IDLE;
            end_short  = 1'b1;
          end
        end
        ST_REPORT: begin
          if (report_ready) begin
            state_next = ST_HALT;
          end
        end
        ST_HALT: begin
          state_next = ST_HALT;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Flags are registered from the next state so they line up with the
  // state register without any input-to-output combinational path.
  always_ff @(posedge clock) begin
    if (reset) begin
      deadlock      <= 1'b0;
      report_valid  <= 1'b0;
      snapshot_axis <= '0;
    end else begin
      deadlock     <= is_deadlocked(state_next);
      report_valid <= (state_next == ST_REPORT);
      if (clear) begin
        snapshot_axis <= '0;
      end else if (snap_load) begin
        snapshot_axis <= axis_block_sigs;
      end
    end
  end

  aesl_stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .start    (cnt_start),
    .incr     (cnt_incr),
    .end_short(end_short),
    .end_long (end_long),
    .cnt      (cnt),
    .max_stall(max_stall)
  );

endmodule
